// File: rtl/pipe_stage_reg_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_skid
//   Pipeline stage register with a valid/ready handshake and a 2-entry skid
//   buffer (MAIN drives the outputs, SKID catches the beat that arrives while
//   MAIN is stalled). in_ready is a pure state decode, so the ready path is
//   registered and never chains combinationally through the stage. A
//   synchronous flush empties the stage; a saturating counter records cycles
//   spent with a beat presented but not taken downstream.
// ---------------------------------------------------------------------------
module pipe_stage_reg_skid #(
   parameter int CTRL_W      = 8,
   parameter int DATA_W      = 132,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_data,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_t state;
   state_t state_nxt;

   entry_t main_q;
   entry_t skid_q;
   entry_t in_entry;

   logic   in_fire;
   logic   out_fire;
   logic   load_main_in;
   logic   load_main_skid;
   logic   load_skid;

   assign in_entry = '{ctrl: in_ctrl, data: in_data};

   // State register; reset forces the stage empty immediately
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; flush wins over any same-cycle handshake
   always_comb begin
      // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (in_fire) state_nxt = ST_ONE;
            end
            ST_ONE: begin
               if (in_fire && !out_fire)      state_nxt = ST_TWO;
               else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
            end
            ST_TWO: begin
               if (out_fire) state_nxt = ST_ONE;
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs and entry-load strobes decoded from the current state
   always_comb begin
      in_ready       = (state != ST_TWO) && !rst;
      out_valid      = (state != ST_EMPTY);
      in_fire        = in_valid && in_ready;
      out_fire       = out_valid && out_ready;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      // A flushed cycle loads nothing: the incoming beat is discarded and the
      // stage reads as empty next cycle regardless of what the entries hold.
      if (!flush) begin
         unique case (state)
            ST_EMPTY: load_main_in = in_fire;
            ST_ONE: begin
               load_main_in = in_fire && out_fire;
               load_skid    = in_fire && !out_fire;
            end
            ST_TWO:   load_main_skid = out_fire;
            default: ;
         endcase
      end
   end

   // Bubbles present an all-zero control bundle so no stray write enables leak
   assign out_ctrl = out_valid ? main_q.ctrl : '0;
   assign out_data = main_q.data;

   // Entry storage; MAIN refills from SKID first so beat order stays FIFO
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: entries are reset because out_data must read zero while rst is held.
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_entry;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   // Back-pressure counter; saturates instead of wrapping, cleared only by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg_skid
//   Cycle table plus hand-written sequences for streaming, stall-counter
//   saturation and asynchronous reset. A FIFO scoreboard collects every
//   accepted beat and checks the order and content of every delivered beat.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg_skid;

   localparam int CTRL_W      = 8;
   localparam int DATA_W      = 132;
   localparam int STALL_CNT_W = 4;

   logic                   clk;
   logic                   rst;
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [CTRL_W-1:0]      in_ctrl;
   logic [DATA_W-1:0]      in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [CTRL_W-1:0]      out_ctrl;
   logic [DATA_W-1:0]      out_data;
   logic [STALL_CNT_W-1:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t sb_q[$];

   typedef struct {
      logic                   iv;
      logic [CTRL_W-1:0]      ctrl;
      logic [DATA_W-1:0]      data;
      logic                   ordy;
      logic                   fl;
      logic                   e_ir;
      logic                   e_ov;
      logic [CTRL_W-1:0]      e_ctrl;
      logic [DATA_W-1:0]      e_data;
      logic [STALL_CNT_W-1:0] e_st;
   } vec_t;

   localparam int N_VEC = 18;
   vec_t vecs[N_VEC];

   pipe_stage_reg_skid #(
      .CTRL_W      (CTRL_W),
      .DATA_W      (DATA_W),
      .STALL_CNT_W (STALL_CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit iv, int c, int d, bit ordy, bit fl,
                               bit e_ir, bit e_ov, int e_c, int e_d, int e_st);
      vec_t v;
      v.iv     = iv;
      v.ctrl   = CTRL_W'(c);
      v.data   = DATA_W'(d);
      v.ordy   = ordy;
      v.fl     = fl;
      v.e_ir   = e_ir;
      v.e_ov   = e_ov;
      v.e_ctrl = CTRL_W'(e_c);
      v.e_data = DATA_W'(e_d);
      v.e_st   = STALL_CNT_W'(e_st);
      return v;
   endfunction

   task automatic drive(input bit iv, input int c, input int d, input bit ordy, input bit fl);
      in_valid  = iv;
      in_ctrl   = CTRL_W'(c);
      in_data   = DATA_W'(d);
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
   endtask

   task automatic apply_row(input vec_t v, input int idx);
      in_valid  = v.iv;
      in_ctrl   = v.ctrl;
      in_data   = v.data;
      out_ready = v.ordy;
      flush     = v.fl;
      @(negedge clk);
      check($sformatf("row%0d_in_ready", idx), 160'(in_ready), 160'(v.e_ir));
      check($sformatf("row%0d_out_valid", idx), 160'(out_valid), 160'(v.e_ov));
      check($sformatf("row%0d_out_ctrl", idx), 160'(out_ctrl), 160'(v.e_ctrl));
      if (v.e_ov) check($sformatf("row%0d_out_data", idx), 160'(out_data), 160'(v.e_data));
      check($sformatf("row%0d_stall_cnt", idx), 160'(stall_cnt), 160'(v.e_st));
      tick();
   endtask

   // Scoreboard monitor: samples mid-cycle, i.e. the values the next edge will see
   always @(negedge clk) begin
      if (rst) begin
         check("mon_rst_in_ready", 160'(in_ready), 160'(0));
         sb_q.delete();
      end else begin
         check("mon_in_ready", 160'(in_ready), 160'(sb_q.size() < 2));
         check("mon_out_valid", 160'(out_valid), 160'(sb_q.size() != 0));
         if (!out_valid) check("mon_bubble_ctrl", 160'(out_ctrl), 160'(0));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("mon_sb_underflow", 160'(1), 160'(0));
            end else begin
               check("mon_beat_ctrl", 160'(out_ctrl), 160'(sb_q[0].ctrl));
               check("mon_beat_data", 160'(out_data), 160'(sb_q[0].data));
               void'(sb_q.pop_front());
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (in_valid && in_ready) begin
            sb_q.push_back('{ctrl: in_ctrl, data: in_data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Cycle table: iv ctrl data ordy fl | in_ready out_valid out_ctrl out_data stall_cnt
      vecs[0]  = mk(1, 'hA5,  1, 1, 0,   1, 0, 'h00,  0, 0);
      vecs[1]  = mk(0, 'h00,  0, 1, 0,   1, 1, 'hA5,  1, 0);
      vecs[2]  = mk(1, 'h11,  2, 0, 0,   1, 0, 'h00,  0, 0);
      vecs[3]  = mk(1, 'h12,  3, 0, 0,   1, 1, 'h11,  2, 0);
      vecs[4]  = mk(1, 'h13,  4, 0, 0,   0, 1, 'h11,  2, 1);
      vecs[5]  = mk(1, 'h13,  4, 0, 0,   0, 1, 'h11,  2, 2);
      vecs[6]  = mk(1, 'h13,  4, 1, 0,   0, 1, 'h11,  2, 3);
      vecs[7]  = mk(1, 'h13,  4, 1, 0,   1, 1, 'h12,  3, 3);
      vecs[8]  = mk(0, 'h00,  0, 1, 0,   1, 1, 'h13,  4, 3);
      vecs[9]  = mk(1, 'h21,  5, 0, 0,   1, 0, 'h00,  0, 3);
      vecs[10] = mk(1, 'h22,  6, 0, 0,   1, 1, 'h21,  5, 3);
      vecs[11] = mk(1, 'h23,  7, 0, 1,   0, 1, 'h21,  5, 4);
      vecs[12] = mk(1, 'h24,  8, 1, 0,   1, 0, 'h00,  0, 5);
      vecs[13] = mk(1, 'h25,  9, 0, 1,   1, 1, 'h24,  8, 5);
      vecs[14] = mk(1, 'h26, 10, 1, 1,   1, 0, 'h00,  0, 6);
      vecs[15] = mk(1, 'h27, 11, 1, 0,   1, 0, 'h00,  0, 6);
      vecs[16] = mk(1, 'h28, 12, 1, 1,   1, 1, 'h27, 11, 6);
      vecs[17] = mk(0, 'h00,  0, 1, 0,   1, 0, 'h00,  0, 6);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #2;
      check("rst_in_ready", 160'(in_ready), 160'(0));
      check("rst_out_valid", 160'(out_valid), 160'(0));
      check("rst_out_ctrl", 160'(out_ctrl), 160'(0));
      check("rst_out_data", 160'(out_data), 160'(0));
      check("rst_stall_cnt", 160'(stall_cnt), 160'(0));
      @(posedge clk);
      #3 rst = 1'b0;
      tick();

      // Single beat, skid fill/drain, back-pressure and flush corners
      for (int i = 0; i < N_VEC; i++) apply_row(vecs[i], i);
      check("table_sb_empty", 160'(sb_q.size()), 160'(0));

      // Streaming at full rate: one beat out per cycle, one cycle behind
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         drive(1, 'h30 + i, i, 1, 0);
         @(negedge clk);
         check($sformatf("stream%0d_in_ready", i), 160'(in_ready), 160'(1));
         if (i > 1) begin
            check($sformatf("stream%0d_out_valid", i), 160'(out_valid), 160'(1));
            check($sformatf("stream%0d_out_data", i), 160'(out_data), 160'(i - 1));
         end
         tick();
      end
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      check("stream_last_data", 160'(out_data), 160'(10));
      tick();
      @(negedge clk);
      check("stream_drained", 160'(out_valid), 160'(0));
      tick();

      // Stall counter saturation over 2^STALL_CNT_W+3 stalled cycles
      do_reset();
      drive(1, 'h5A, 'h77, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < (1 << STALL_CNT_W) + 3; k++) begin
         @(negedge clk);
         check($sformatf("sat%0d_stall_cnt", k), 160'(stall_cnt),
               160'((k > (1 << STALL_CNT_W) - 1) ? (1 << STALL_CNT_W) - 1 : k));
         tick();
      end
      drive(0, 0, 0, 1, 0);
      tick();
      @(negedge clk);
      check("sat_hold_after_drain", 160'(stall_cnt), 160'((1 << STALL_CNT_W) - 1));
      tick();

      // Asynchronous reset while both entries are full
      do_reset();
      drive(1, 'h61, 'h100, 0, 0);
      tick();
      drive(1, 'h62, 'h101, 0, 0);
      tick();
      drive(1, 'h63, 'h102, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_in_ready", 160'(in_ready), 160'(0));
      check("arst_out_valid", 160'(out_valid), 160'(0));
      check("arst_out_ctrl", 160'(out_ctrl), 160'(0));
      check("arst_out_data", 160'(out_data), 160'(0));
      check("arst_stall_cnt", 160'(stall_cnt), 160'(0));
      @(posedge clk);
      #3 rst = 1'b0;
      drive(1, 'h64, 'h200, 1, 0);
      @(negedge clk);
      check("arst_first_pre", 160'(out_valid), 160'(0));
      tick();
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      check("arst_first_valid", 160'(out_valid), 160'(1));
      check("arst_first_ctrl", 160'(out_ctrl), 160'('h64));
      check("arst_first_data", 160'(out_data), 160'('h200));
      tick();
      @(negedge clk);
      check("final_sb_empty", 160'(sb_q.size()), 160'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
